// File: rtl/flexpipe_pkg.sv
// Shared memory-port types for the flexpipe fabric and the DRAM responder model.
// Holds the request/response payload structs and the LFSR step used by the stall option.
package flexpipe_pkg;

   localparam int unsigned ADDR_WIDTH           = 32;
   localparam int unsigned DATA_WIDTH           = 32;
   localparam int unsigned REQ_ID_WIDTH         = 4;
   localparam int unsigned BURST_LEN_WIDTH      = 4;
   localparam int unsigned DRAM_DEFAULT_LATENCY = 4;

   // len is the beat count minus one
   typedef struct packed {
      logic [ADDR_WIDTH-1:0]      addr;
      logic [REQ_ID_WIDTH-1:0]    id;
      logic [BURST_LEN_WIDTH-1:0] len;
   } mem_req_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]   data;
      logic [REQ_ID_WIDTH-1:0] id;
      logic                    last;
   } mem_resp_t;

   // Fibonacci LFSR, taps 16,14,13,11
   function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/dram_req_fifo.sv
// In-order request queue for the DRAM responder; full/empty are registered flags.
module dram_req_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_n;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_comb begin
      count_n = count;
      case ({do_push, do_pop})
         2'b10:   count_n = count + CNT_W'(1);
         2'b01:   count_n = count - CNT_W'(1);
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_n;
         full  <= (count_n == CNT_W'(DEPTH));
         empty <= (count_n == CNT_W'(0));
      end
   end

   // Storage needs no reset; the empty flag guards stale entries
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/dram_responder.sv
// Behavioural DRAM end of the arbiter master port: in-order reads, fixed latency, bursts.
// Define DRAM_RESP_STALL_EN to add LFSR-driven beat stalls inside bursts.
module dram_responder
   import flexpipe_pkg::*;
#(
   parameter int unsigned           REQ_DEPTH     = 4,
   parameter int unsigned           LATENCY       = DRAM_DEFAULT_LATENCY,
   parameter int unsigned           MEM_ADDR_BITS = 16,
   parameter logic [DATA_WIDTH-1:0] DATA_SEED     = 32'hA5A5_0000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  mem_req_t                       req,
   input  logic                           req_valid,
   output logic                           req_ready,
   output mem_resp_t                      resp,
   output logic                           resp_valid,
   output logic [$clog2(REQ_DEPTH+2)-1:0] outstanding
);

   localparam int unsigned LAT_W  = $clog2(LATENCY + 1);
   localparam int unsigned OUT_W  = $clog2(REQ_DEPTH + 2);
   localparam int unsigned FIFO_W = MEM_ADDR_BITS + REQ_ID_WIDTH + BURST_LEN_WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;

   logic [1:0]                 state, state_n;
   logic [LAT_W-1:0]           lat_cnt, lat_n;
   logic [BURST_LEN_WIDTH-1:0] beat, beat_n;
   logic [MEM_ADDR_BITS-1:0]   cur_addr, cur_addr_n;
   logic [REQ_ID_WIDTH-1:0]    cur_id, cur_id_n;
   logic [BURST_LEN_WIDTH-1:0] cur_len, cur_len_n;
   logic [MEM_ADDR_BITS-1:0]   head_addr;
   logic [REQ_ID_WIDTH-1:0]    head_id;
   logic [BURST_LEN_WIDTH-1:0] head_len;
   logic [MEM_ADDR_BITS-1:0]   word_addr;
   logic [FIFO_W-1:0]          fifo_rdata;
   logic                       fifo_full, fifo_empty;
   logic                       accept, pop;
   logic                       stall, stall_n;
   mem_resp_t                  resp_n;
   logic                       resp_valid_n;

   assign req_ready = !fifo_full;
   assign accept    = req_valid && req_ready;
   assign {head_addr, head_id, head_len} = fifo_rdata;

   dram_req_fifo #(
      .DEPTH (REQ_DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .wdata ({req.addr[MEM_ADDR_BITS-1:0], req.id, req.len}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   if (MEM_ADDR_BITS < ADDR_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req.addr[ADDR_WIDTH-1:MEM_ADDR_BITS];
   end

`ifdef DRAM_RESP_STALL_EN
   logic [15:0] lfsr;
   logic [15:0] lfsr_n;

   assign lfsr_n  = lfsr16_next(lfsr);
   assign stall   = (state == S_BURST) && lfsr[0];
   assign stall_n = lfsr_n[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= lfsr_n;
   end
`else
   assign stall   = 1'b0;
   assign stall_n = 1'b0;
`endif

   // Next-state logic; response outputs are precomputed from next state so they register cleanly
   always_comb begin
      state_n      = state;
      lat_n        = lat_cnt;
      beat_n       = beat;
      cur_addr_n   = cur_addr;
      cur_id_n     = cur_id;
      cur_len_n    = cur_len;
      pop          = 1'b0;
      resp_n       = '0;
      resp_valid_n = 1'b0;
      word_addr    = '0;

      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               cur_addr_n = head_addr;
               cur_id_n   = head_id;
               cur_len_n  = head_len;
               lat_n      = LAT_W'(LATENCY - 1);
               state_n    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (lat_cnt == LAT_W'(0)) begin
               state_n = S_BURST;
               beat_n  = '0;
            end else begin
               lat_n = lat_cnt - LAT_W'(1);
            end
         end
         S_BURST: begin
            if (!stall) begin
               if (beat == cur_len) begin
                  if (!fifo_empty) begin
                     pop        = 1'b1;
                     cur_addr_n = head_addr;
                     cur_id_n   = head_id;
                     cur_len_n  = head_len;
                     lat_n      = LAT_W'(LATENCY - 1);
                     state_n    = S_WAIT;
                  end else begin
                     state_n = S_IDLE;
                  end
               end else begin
                  beat_n = beat + BURST_LEN_WIDTH'(1);
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      resp_valid_n = (state_n == S_BURST) && !stall_n;
      if (resp_valid_n) begin
         word_addr   = cur_addr_n + MEM_ADDR_BITS'(beat_n);
         resp_n.data = DATA_WIDTH'(word_addr) ^ DATA_SEED;
         resp_n.id   = cur_id_n;
         resp_n.last = (beat_n == cur_len_n);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         lat_cnt    <= '0;
         beat       <= '0;
         cur_addr   <= '0;
         cur_id     <= '0;
         cur_len    <= '0;
         resp       <= '0;
         resp_valid <= 1'b0;
      end else begin
         state      <= state_n;
         lat_cnt    <= lat_n;
         beat       <= beat_n;
         cur_addr   <= cur_addr_n;
         cur_id     <= cur_id_n;
         cur_len    <= cur_len_n;
         resp       <= resp_n;
         resp_valid <= resp_valid_n;
      end
   end

   // Accepted-but-unfinished requests; accept and final beat together cancel out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
      end else if (accept && !(resp_valid && resp.last)) begin
         outstanding <= outstanding + OUT_W'(1);
      end else if (!accept && resp_valid && resp.last) begin
         outstanding <= outstanding - OUT_W'(1);
      end
   end

endmodule

// File: tb/tb_dram_responder.sv
// Directed self-checking bench for dram_responder (default build, no stalls).
module tb_dram_responder;
   import flexpipe_pkg::*;

   logic      clk;
   logic      rst;
   mem_req_t  req;
   logic      req_valid;
   logic      req_ready;
   mem_resp_t resp;
   logic      resp_valid;
   logic [2:0] outstanding;

   int vec;
   int miss;

   dram_responder dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .resp        (resp),
      .resp_valid  (resp_valid),
      .outstanding (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] dat(input logic [15:0] a);
      return {16'h0000, a} ^ 32'hA5A5_0000;
   endfunction

   // Present one request for a single cycle; returns one cycle later
   task automatic send(input logic [31:0] a, input logic [3:0] id, input logic [3:0] len);
      req.addr  = a;
      req.id    = id;
      req.len   = len;
      req_valid = 1'b1;
      step(1);
      req_valid = 1'b0;
   endtask

   task automatic chk_beat(input string tag, input logic [15:0] a, input logic [3:0] id,
                           input logic last);
      chk({tag, ".valid"}, 64'(resp_valid), 64'(1));
      chk({tag, ".data"},  64'(resp.data),  64'(dat(a)));
      chk({tag, ".id"},    64'(resp.id),    64'(id));
      chk({tag, ".last"},  64'(resp.last),  64'(last));
   endtask

   logic [31:0] exp_data [48];
   logic [3:0]  exp_id   [48];
   logic        exp_last [48];

   initial begin
      int got;
      int sent;
      int max_out;
      int first_low;

      vec = 0;
      miss = 0;
      rst = 1'b1;
      req = '0;
      req_valid = 1'b0;

      // Reset state
      #3;
      chk("rst.req_ready",   64'(req_ready),   64'(1));
      chk("rst.resp_valid",  64'(resp_valid),  64'(0));
      chk("rst.resp",        64'(resp),        64'(0));
      chk("rst.outstanding", 64'(outstanding), 64'(0));
      step(2);
      rst = 1'b0;
      step(2);

      // Single beat: accept at T, beat at T+6, outstanding 0 at T+7
      send(32'h10, 4'h3, 4'd0);
      chk("single.out_t1", 64'(outstanding), 64'(1));
      step(4);
      chk("single.t5_idle", 64'(resp_valid), 64'(0));
      step(1);
      chk_beat("single.t6", 16'h0010, 4'h3, 1'b1);
      chk("single.out_t6", 64'(outstanding), 64'(1));
      step(1);
      chk("single.out_t7", 64'(outstanding), 64'(0));
      chk("single.t7_valid", 64'(resp_valid), 64'(0));
      chk("single.t7_resp", 64'(resp), 64'(0));
      step(2);

      // Four-beat burst
      send(32'h20, 4'h5, 4'd3);
      step(5);
      for (int b = 0; b < 4; b++) begin
         chk_beat($sformatf("burst4.b%0d", b), 16'(16'h20 + b), 4'h5, 1'(b == 3));
         step(1);
      end
      chk("burst4.after", 64'(resp_valid), 64'(0));
      step(2);

      // Address wrap within the burst (upper address bits ignored)
      send(32'h1234_FFFE, 4'h9, 4'd3);
      step(5);
      chk_beat("wrap.b0", 16'hFFFE, 4'h9, 1'b0);
      step(1);
      chk_beat("wrap.b1", 16'hFFFF, 4'h9, 1'b0);
      step(1);
      chk_beat("wrap.b2", 16'h0000, 4'h9, 1'b0);
      step(1);
      chk_beat("wrap.b3", 16'h0001, 4'h9, 1'b1);
      step(3);

      // Back-to-back: second first beat LATENCY+1 cycles after first last beat
      send(32'h40, 4'h1, 4'd1);
      send(32'h80, 4'h2, 4'd1);
      chk("b2b.out_t2", 64'(outstanding), 64'(2));
      step(4);
      chk_beat("b2b.r1b0", 16'h0040, 4'h1, 1'b0);
      step(1);
      chk_beat("b2b.r1b1", 16'h0041, 4'h1, 1'b1);
      for (int g = 0; g < 4; g++) begin
         step(1);
         chk($sformatf("b2b.gap%0d", g), 64'(resp_valid), 64'(0));
      end
      step(1);
      chk_beat("b2b.r2b0", 16'h0080, 4'h2, 1'b0);
      step(1);
      chk_beat("b2b.r2b1", 16'h0081, 4'h2, 1'b1);
      step(3);

      // Backpressure: six len=7 requests, in-order return of 48 beats
      for (int i = 0; i < 6; i++) begin
         for (int b = 0; b < 8; b++) begin
            exp_data[i*8+b] = dat(16'(16'h100 * i + b));
            exp_id[i*8+b]   = 4'(i);
            exp_last[i*8+b] = (b == 7);
         end
      end
      got = 0;
      sent = 0;
      max_out = 0;
      first_low = -1;
      for (int cyc = 0; cyc < 400 && got < 48; cyc++) begin
         if (resp_valid) begin
            chk($sformatf("bp.data%0d", got), 64'(resp.data), 64'(exp_data[got]));
            chk($sformatf("bp.id%0d", got),   64'(resp.id),   64'(exp_id[got]));
            chk($sformatf("bp.last%0d", got), 64'(resp.last), 64'(exp_last[got]));
            got++;
         end
         if (int'(outstanding) > max_out) max_out = int'(outstanding);
         if (!req_ready && first_low < 0) first_low = cyc;
         if (sent < 6) begin
            req.addr  = 32'(32'h100 * sent);
            req.id    = 4'(sent);
            req.len   = 4'd7;
            req_valid = 1'b1;
            if (req_ready) sent++;
         end else begin
            req_valid = 1'b0;
         end
         step(1);
      end
      req_valid = 1'b0;
      chk("bp.beats_received", 64'(got), 64'(48));
      chk("bp.all_sent", 64'(sent), 64'(6));
      chk("bp.ready_low_cycle", 64'(first_low), 64'(5));
      chk("bp.max_outstanding", 64'(max_out), 64'(5));
      step(1);
      chk("bp.out_end", 64'(outstanding), 64'(0));
      step(2);

      // Reset mid-burst discards the burst and the queued request
      req.addr  = 32'h300;
      req.id    = 4'h7;
      req.len   = 4'd7;
      req_valid = 1'b1;
      step(1);
      req.addr  = 32'h400;
      req.id    = 4'h6;
      req.len   = 4'd0;
      step(1);
      req_valid = 1'b0;
      step(6);
      chk_beat("rstmid.b2", 16'h0302, 4'h7, 1'b0);
      chk("rstmid.out_before", 64'(outstanding), 64'(2));
      rst = 1'b1;
      #1;
      chk("rstmid.valid", 64'(resp_valid), 64'(0));
      chk("rstmid.out", 64'(outstanding), 64'(0));
      chk("rstmid.ready", 64'(req_ready), 64'(1));
      step(2);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step(1);
         chk($sformatf("rstmid.quiet%0d", c), 64'({resp_valid, outstanding}), 64'(0));
      end
      send(32'h55, 4'h9, 4'd0);
      step(4);
      chk("rstmid.new_t5", 64'(resp_valid), 64'(0));
      step(1);
      chk_beat("rstmid.new", 16'h0055, 4'h9, 1'b1);
      step(1);
      chk("rstmid.new_out", 64'(outstanding), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
